// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_READ registered read ports,
// one write port and a post-reset clear sequencer.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; restarts the clear sequence
//   readReg    NUM_READ packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   readData   NUM_READ packed registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   writeReg   write address
//   writeData  write data
//   write      write enable (ignored while busy)
//   busy       high while the clear sequence is zeroing the array
//
// Build option:
//   REGFILE_ZERO_REG_EN  when defined, entry 0 is hardwired to zero: writes to
//                        address 0 are dropped and reads of address 0 (including
//                        the forwarding path) return 0.
//
// WRITE_FIRST = 1 forwards a same-edge write to a matching read port;
// WRITE_FIRST = 0 returns the pre-write contents.

module regfile_mp #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned NUM_READ    = 2,
    parameter int unsigned WRITE_FIRST = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0]   readData,
    input  logic [ADDR_WIDTH-1:0]            writeReg,
    input  logic [DATA_WIDTH-1:0]            writeData,
    input  logic                             write,
    output logic                             busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   ptr_nxt;
    logic                    busy_nxt;

    // Memory write port, shared by the clear sequencer and the user write.
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    user_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [NUM_READ*DATA_WIDTH-1:0] rd_nxt;
    logic [ADDR_WIDTH-1:0]          rd_addr;

    // State, clear pointer and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state and memory write control.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy_nxt  = busy;
        mem_we    = 1'b0;
        mem_addr  = writeReg;
        mem_wdata = writeData;
        user_we   = 1'b0;

        case (state)
            CLEAR: begin
                busy_nxt  = 1'b1;
                mem_we    = ~rst;
                mem_addr  = ptr;
                mem_wdata = '0;
                ptr_nxt   = ptr + ADDR_WIDTH'(1);
                if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_nxt = READY;
                    busy_nxt  = 1'b0;
                end
            end
            READY: begin
                busy_nxt = 1'b0;
                // Writes to the hardwired zero entry never reach the array.
                user_we  = write & ~rst & ~(ZERO_REG && (writeReg == '0));
                mem_we   = user_we;
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
                busy_nxt  = 1'b1;
            end
        endcase
    end

    // Storage array; cleared by the sequencer rather than by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Per-port read mux with optional write forwarding.
    always_comb begin
        rd_nxt  = '0;
        rd_addr = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            rd_addr = readReg[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (state != READY) begin
                rd_nxt[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (ZERO_REG && (rd_addr == '0)) begin
                rd_nxt[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((WRITE_FIRST != 0) && user_we && (writeReg == rd_addr)) begin
                rd_nxt[i*DATA_WIDTH +: DATA_WIDTH] = writeData;
            end else begin
                rd_nxt[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr];
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            readData <= '0;
        end else begin
            readData <= rd_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp at default sizes.
// Two instances share every input: u_wf1 (WRITE_FIRST=1) and u_wf0 (WRITE_FIRST=0).

module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  readReg;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        write;
    logic [63:0] rd_wf1;
    logic [63:0] rd_wf0;
    logic        busy_wf1;
    logic        busy_wf0;

    int n_total;
    int n_pass;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [31:0] R0_VAL = 32'h0000_0000;
`else
    localparam logic [31:0] R0_VAL = 32'hFFFF_FFFF;
`endif

    regfile_mp #(.WRITE_FIRST(1)) u_wf1 (
        .clk       (clk),
        .rst       (rst),
        .readReg   (readReg),
        .readData  (rd_wf1),
        .writeReg  (writeReg),
        .writeData (writeData),
        .write     (write),
        .busy      (busy_wf1)
    );

    regfile_mp #(.WRITE_FIRST(0)) u_wf0 (
        .clk       (clk),
        .rst       (rst),
        .readReg   (readReg),
        .readData  (rd_wf0),
        .writeReg  (writeReg),
        .writeData (writeData),
        .write     (write),
        .busy      (busy_wf0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0_wf1;
        logic [31:0] e1_wf1;
        logic [31:0] e0_wf0;
        logic [31:0] e1_wf0;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_read(input logic [4:0] a0, input logic [4:0] a1);
        readReg = {a1, a0};
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        write     = 1'b0;
        writeReg  = '0;
        writeData = '0;
        readReg   = '0;

        // Vectors applied after the initial clear (array all zero).
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd7,  32'h11,       5'd5,  5'd7,  32'hDEADBEEF, 32'h11,       32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  32'h22,       32'h22,       32'h11,       32'h11};
        vecs[4]  = '{1'b0, 5'd7,  32'h99,       5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 32'h22,       32'hDEADBEEF};
        vecs[5]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0,  32'hA5A5A5A5, 32'h0,        32'h0,        32'h0};
        vecs[6]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd31, R0_VAL,       32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd3,  R0_VAL,       32'h0,        R0_VAL,       32'h0};
        vecs[8]  = '{1'b0, 5'd3,  32'h12345678, 5'd3,  5'd3,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h0,        R0_VAL,       32'h0,        R0_VAL};
        vecs[10] = '{1'b1, 5'd1,  32'h1,        5'd1,  5'd31, 32'h1,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};

        // Reset held for two edges.
        tick();
        tick();
        chk("rst_busy_wf1", 32'(busy_wf1), 32'd1);
        chk("rst_busy_wf0", 32'(busy_wf0), 32'd1);
        chk("rst_rd_wf1_lo", rd_wf1[31:0], 32'h0);
        chk("rst_rd_wf1_hi", rd_wf1[63:32], 32'h0);
        chk("rst_rd_wf0_lo", rd_wf0[31:0], 32'h0);

        // Clear sequence with a write attempt to r3 throughout.
        rst       = 1'b0;
        write     = 1'b1;
        writeReg  = 5'd3;
        writeData = 32'h55;
        set_read(5'd3, 5'd3);
        for (int e = 1; e < 32; e++) begin
            tick();
            chk("clear_busy_wf1", 32'(busy_wf1), 32'd1);
            chk("clear_busy_wf0", 32'(busy_wf0), 32'd1);
            chk("clear_rd_wf1", rd_wf1[31:0], 32'h0);
        end
        tick();
        chk("clear_done_wf1", 32'(busy_wf1), 32'd0);
        chk("clear_done_wf0", 32'(busy_wf0), 32'd0);
        chk("clear_done_rd", rd_wf1[63:32], 32'h0);
        write = 1'b0;

        // Every entry reads zero after the clear (r3 included).
        for (int a = 0; a < 32; a++) begin
            set_read(5'(a), 5'(31 - a));
            tick();
            chk("post_clear_p0", rd_wf1[31:0], 32'h0);
            chk("post_clear_p1", rd_wf0[63:32], 32'h0);
        end

        // Directed read/write vectors.
        for (int v = 0; v < NVEC; v++) begin
            write     = vecs[v].we;
            writeReg  = vecs[v].wa;
            writeData = vecs[v].wd;
            set_read(vecs[v].ra0, vecs[v].ra1);
            tick();
            chk($sformatf("vec%0d_wf1_p0", v), rd_wf1[31:0],  vecs[v].e0_wf1);
            chk($sformatf("vec%0d_wf1_p1", v), rd_wf1[63:32], vecs[v].e1_wf1);
            chk($sformatf("vec%0d_wf0_p0", v), rd_wf0[31:0],  vecs[v].e0_wf0);
            chk($sformatf("vec%0d_wf0_p1", v), rd_wf0[63:32], vecs[v].e1_wf0);
        end
        write = 1'b0;

        // Read data is held while the address stays put.
        tick();
        chk("hold_wf1_p0", rd_wf1[31:0], 32'h1);
        chk("hold_wf0_p0", rd_wf0[31:0], 32'h1);

        // Reset reasserted in READY, then again after 10 clear edges.
        rst = 1'b1;
        tick();
        chk("rst2_busy", 32'(busy_wf1), 32'd1);
        chk("rst2_rd_lo", rd_wf1[31:0], 32'h0);
        chk("rst2_rd_hi", rd_wf1[63:32], 32'h0);
        rst = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
        end
        chk("mid_busy", 32'(busy_wf1), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e < 32; e++) begin
            tick();
            chk("restart_busy_wf1", 32'(busy_wf1), 32'd1);
            chk("restart_busy_wf0", 32'(busy_wf0), 32'd1);
        end
        tick();
        chk("restart_done_wf1", 32'(busy_wf1), 32'd0);
        chk("restart_done_wf0", 32'(busy_wf0), 32'd0);

        // Previously written entries are zero after the full clear.
        set_read(5'd5, 5'd31);
        tick();
        chk("recleared_r5", rd_wf1[31:0], 32'h0);
        chk("recleared_r31", rd_wf0[63:32], 32'h0);
        set_read(5'd7, 5'd1);
        tick();
        chk("recleared_r7", rd_wf0[31:0], 32'h0);
        chk("recleared_r1", rd_wf1[63:32], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
